// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RISC-V core.
// It takes the register-file read data and the decoded fields into EX.
// It adds a bypass from the write-back port, inserts a bubble on load-use,
// and supports flush and hold. A saturating counter tracks load-use bubbles.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_imm,
  input  logic [6:0]      id_ctrl,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [6:0]      ex_ctrl,
  output logic [15:0]     bubble_cnt
);

  // Bit position of mem_read inside the packed control word.
  localparam int MEM_READ_BIT = 5;

  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;
  logic            lu;

  // Pick each operand. x0 is always zero. A write-back to the same register
  // on this edge overrides the stale register-file read.
  always_comb begin
    op1_sel = rf_data1;
    op2_sel = rf_data2;
    if (id_rs1 == 5'd0) begin
      op1_sel = '0;
    end else if (wb_reg_write && (wb_rd == id_rs1)) begin
      op1_sel = wb_data;
    end
    if (id_rs2 == 5'd0) begin
      op2_sel = '0;
    end else if (wb_reg_write && (wb_rd == id_rs2)) begin
      op2_sel = wb_data;
    end
  end

  // A load-use hazard occurs when the load in EX writes a register that decode needs.
  assign lu = id_valid & ex_valid & ex_ctrl[MEM_READ_BIT] & (ex_rd != 5'd0)
            & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A flush cancels the load-use stall, because upstream is being redirected anyway.
  assign stall_id = (lu & ~flush) | hold;

  // ID/EX register: flush beats hold, hold beats a load-use bubble, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else if (flush || (!hold && lu)) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else if (!hold) begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_op1   <= op1_sel;
      ex_op2   <= op2_sel;
      ex_imm   <= id_imm;
      ex_ctrl  <= id_valid ? id_ctrl : 7'd0;
    end
  end

  // Count only the bubbles that load-use actually inserts, and stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (lu && !flush && !hold && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. It checks with immediate assertions.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [PC_W-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_imm;
  logic [6:0]      id_ctrl;
  logic [XLEN-1:0] rf_data1;
  logic [XLEN-1:0] rf_data2;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            hold;
  logic            stall_id;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_imm;
  logic [6:0]      ex_ctrl;
  logic [15:0]     bubble_cnt;

  int compared;
  int mismatched;

  // Control words: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op}
  localparam logic [6:0] CTRL_ALU  = 7'b1000010;
  localparam logic [6:0] CTRL_LOAD = 7'b1101100;

  id_ex_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  // Free-running clock with a period of 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [PC_W-1:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [XLEN-1:0] imm,
                               input logic [6:0] ctrl, input logic [XLEN-1:0] d1,
                               input logic [XLEN-1:0] d2);
    id_valid = v;
    id_pc    = pc;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
    id_imm   = imm;
    id_ctrl  = ctrl;
    rf_data1 = d1;
    rf_data2 = d2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    wb_reg_write = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = '0;
    flush        = 1'b0;
    hold         = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 7'd0, 32'h0, 32'h0);
    #12;
    checkOutput("reset_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_cnt", {16'd0, bubble_cnt}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall_id}, 32'd0);
    rst_n = 1'b1;

    // Basic capture; rs2 is x0, so op2 must be zero even though rf_data2 is not.
    applyStimulus(1'b1, 32'h100, 5'd7, 5'd0, 5'd3, 32'hFFFF_FFFC, CTRL_ALU, 32'd2022, 32'd55);
    step();
    checkOutput("cap_op1", ex_op1, 32'd2022);
    checkOutput("cap_op2", ex_op2, 32'd0);
    checkOutput("cap_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("cap_pc", ex_pc, 32'h100);
    checkOutput("cap_imm", ex_imm, 32'hFFFF_FFFC);
    checkOutput("cap_rd", {27'd0, ex_rd}, 32'd3);
    checkOutput("cap_ctrl", {25'd0, ex_ctrl}, {25'd0, CTRL_ALU});

    // Write-back bypass on rs2.
    applyStimulus(1'b1, 32'h104, 5'd4, 5'd17, 5'd6, 32'd1, CTRL_ALU, 32'd11, 32'd0);
    wb_reg_write = 1'b1;
    wb_rd        = 5'd17;
    wb_data      = 32'd2023;
    step();
    checkOutput("byp_op2", ex_op2, 32'd2023);
    checkOutput("byp_op1", ex_op1, 32'd11);
    // A write to x0 must not bypass, and x0 still reads as zero.
    applyStimulus(1'b1, 32'h108, 5'd4, 5'd0, 5'd6, 32'd1, CTRL_ALU, 32'd11, 32'd77);
    wb_rd   = 5'd0;
    wb_data = 32'd99;
    step();
    checkOutput("byp_x0", ex_op2, 32'd0);
    // With no write-back enable, the register-file value is used.
    applyStimulus(1'b1, 32'h10C, 5'd17, 5'd17, 5'd6, 32'd1, CTRL_ALU, 32'd33, 32'd34);
    wb_reg_write = 1'b0;
    wb_rd        = 5'd17;
    wb_data      = 32'd2023;
    step();
    checkOutput("nobyp_op1", ex_op1, 32'd33);
    checkOutput("nobyp_op2", ex_op2, 32'd34);

    // Load-use hazard: load x5, then use x5.
    applyStimulus(1'b1, 32'h200, 5'd1, 5'd2, 5'd5, 32'd0, CTRL_LOAD, 32'd1, 32'd2);
    step();
    applyStimulus(1'b1, 32'h204, 5'd5, 5'd6, 5'd8, 32'd0, CTRL_ALU, 32'd500, 32'd600);
    #1;
    checkOutput("lu_stall", {31'd0, stall_id}, 32'd1);
    step();
    checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_bubble_ctrl", {25'd0, ex_ctrl}, 32'd0);
    checkOutput("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
    checkOutput("lu_stall_clear", {31'd0, stall_id}, 32'd0);
    step();
    checkOutput("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("lu_cap_rd", {27'd0, ex_rd}, 32'd8);
    checkOutput("lu_cap_op1", ex_op1, 32'd500);

    // A hold held for three cycles freezes EX while ID changes.
    hold = 1'b1;
    applyStimulus(1'b1, 32'h300, 5'd9, 5'd10, 5'd11, 32'd5, CTRL_LOAD, 32'd900, 32'd901);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("hold_stall", {31'd0, stall_id}, 32'd1);
      step();
      checkOutput("hold_rd", {27'd0, ex_rd}, 32'd8);
      checkOutput("hold_op1", ex_op1, 32'd500);
      checkOutput("hold_pc", ex_pc, 32'h204);
    end

    // Hold together with load-use: registers stay and no bubble is counted.
    hold = 1'b0;
    applyStimulus(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, 32'd0, CTRL_LOAD, 32'd1, 32'd2);
    step();
    hold = 1'b1;
    applyStimulus(1'b1, 32'h404, 5'd3, 5'd5, 5'd8, 32'd0, CTRL_ALU, 32'd1, 32'd2);
    #1;
    checkOutput("holdlu_stall", {31'd0, stall_id}, 32'd1);
    step();
    checkOutput("holdlu_pc", ex_pc, 32'h400);
    checkOutput("holdlu_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("holdlu_cnt", {16'd0, bubble_cnt}, 32'd1);

    // Flush together with load-use: flush wins, with no stall and no count.
    hold  = 1'b0;
    flush = 1'b1;
    #1;
    checkOutput("flushlu_stall", {31'd0, stall_id}, 32'd0);
    step();
    checkOutput("flushlu_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flushlu_ctrl", {25'd0, ex_ctrl}, 32'd0);
    checkOutput("flushlu_rd", {27'd0, ex_rd}, 32'd0);
    checkOutput("flushlu_cnt", {16'd0, bubble_cnt}, 32'd1);

    // Flush together with hold: the bubble still loads.
    flush = 1'b0;
    applyStimulus(1'b1, 32'h500, 5'd1, 5'd2, 5'd9, 32'd0, CTRL_ALU, 32'd1, 32'd2);
    step();
    flush = 1'b1;
    hold  = 1'b1;
    #1;
    checkOutput("flushhold_stall", {31'd0, stall_id}, 32'd1);
    step();
    checkOutput("flushhold_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flushhold_ctrl", {25'd0, ex_ctrl}, 32'd0);

    // An invalid decode slot captures with its control forced to zero.
    flush = 1'b0;
    hold  = 1'b0;
    applyStimulus(1'b0, 32'h600, 5'd1, 5'd2, 5'd3, 32'd0, 7'h7F, 32'd1, 32'd2);
    step();
    checkOutput("inv_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("inv_ctrl", {25'd0, ex_ctrl}, 32'd0);
    checkOutput("inv_rd", {27'd0, ex_rd}, 32'd3);

    // Saturation: preload the counter near its limit, then force two bubbles.
    force dut.bubble_cnt = 16'hFFFE;
    #1;
    release dut.bubble_cnt;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h700, 5'd1, 5'd2, 5'd5, 32'd0, CTRL_LOAD, 32'd1, 32'd2);
      step();
      applyStimulus(1'b1, 32'h704, 5'd5, 5'd5, 5'd8, 32'd0, CTRL_ALU, 32'd1, 32'd2);
      step();
      checkOutput("sat_cnt", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    end

    // Asynchronous reset in the middle of a hold, away from any clock edge.
    step();
    hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("areset_pc", ex_pc, 32'd0);
    checkOutput("areset_op1", ex_op1, 32'd0);
    checkOutput("areset_cnt", {16'd0, bubble_cnt}, 32'd0);
    checkOutput("areset_stall_hold", {31'd0, stall_id}, 32'd1);
    hold = 1'b0;
    #1;
    checkOutput("areset_stall", {31'd0, stall_id}, 32'd0);
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
